// File: rtl/source_selector.sv
// source_selector: registered N-channel source mux with break-before-make blanking, auto-scan, freeze and illegal-select flag
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_data                  CHANNELS sources packed, channel k at [k*WIDTH +: WIDTH]
//   i_valid                 per-channel data valid
//   i_sel                   manual channel select
//   i_mode                  0 = manual, 1 = auto-scan
//   i_freeze                hold result/result_valid and pause dwell
//   o_result, o_result_valid  registered routed data and valid
//   o_active_ch             channel currently routed
//   o_switching             high while blanking between channels
//   o_sel_err               manual select out of range
module source_selector #(
  parameter int WIDTH = 3,
  parameter int CHANNELS = 4,
  parameter int BLANK_CYC = 2,
  parameter int DWELL = 8,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic                      i_mode,
  input  logic                      i_freeze,
  output logic [WIDTH-1:0]          o_result,
  output logic                      o_result_valid,
  output logic [SEL_W-1:0]          o_active_ch,
  output logic                      o_switching,
  output logic                      o_sel_err
);
  localparam int BC_W = $clog2(BLANK_CYC + 1);
  localparam int DW_W = $clog2(DWELL);
  typedef enum logic {RUN, BLANK} state_t;
  state_t r_state, w_state;
  logic [SEL_W-1:0] r_active, w_active, r_pend, w_pend, w_target, w_next;
  logic [BC_W-1:0] r_blank, w_blank;
  logic [DW_W-1:0] r_dwell, w_dwell;
  logic [WIDTH-1:0] r_result, w_result;
  logic r_valid, w_valid, r_switching, w_switching, r_sel_err, w_sel_err, w_sel_ok;
  logic [WIDTH-1:0] w_ch [CHANNELS];
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign w_ch[k] = i_data[k*WIDTH +: WIDTH];
  end
  assign w_sel_ok = {1'b0, i_sel} < (SEL_W+1)'(CHANNELS);
  assign w_next = (r_active == SEL_W'(CHANNELS - 1)) ? '0 : r_active + 1'b1;
  // scan advance is suppressed while frozen so a frozen channel never starts a switch
  assign w_target = i_mode ? ((r_dwell == DW_W'(DWELL - 1) && !i_freeze) ? w_next : r_active)
                           : (w_sel_ok ? i_sel : r_active);
  always_comb begin
    w_state = r_state;
    w_active = r_active;
    w_pend = r_pend;
    w_blank = r_blank;
    w_dwell = r_dwell;
    w_result = r_result;
    w_valid = r_valid;
    w_switching = 1'b0;
    w_sel_err = 1'b0;
    if (r_state == BLANK) begin
      w_result = '0;
      w_valid = 1'b0;
      w_switching = 1'b1;
      w_blank = r_blank - 1'b1;
      if (r_blank == '0) begin
        w_state = RUN;
        w_active = r_pend;
        w_switching = 1'b0;
        w_blank = '0;
        w_result = w_ch[r_pend];
        w_valid = i_valid[r_pend];
      end
    end else begin
      w_sel_err = !i_mode && !w_sel_ok;
      if (w_target != r_active) begin
        w_state = BLANK;
        w_pend = w_target;
        w_blank = BC_W'(BLANK_CYC - 1);
        w_dwell = '0;
        w_result = '0;
        w_valid = 1'b0;
        w_switching = 1'b1;
      end else begin
        w_result = i_freeze ? r_result : w_ch[r_active];
        w_valid = i_freeze ? r_valid : i_valid[r_active];
        // held at zero in manual mode, so entering scan always starts a fresh dwell
        w_dwell = !i_mode ? '0 : i_freeze ? r_dwell : r_dwell + 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RUN;
      r_active <= '0;
      r_pend <= '0;
      r_blank <= '0;
      r_dwell <= '0;
      r_result <= '0;
      r_valid <= 1'b0;
      r_switching <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_active <= w_active;
      r_pend <= w_pend;
      r_blank <= w_blank;
      r_dwell <= w_dwell;
      r_result <= w_result;
      r_valid <= w_valid;
      r_switching <= w_switching;
      r_sel_err <= w_sel_err;
    end
  end
  assign o_result = r_result;
  assign o_result_valid = r_valid;
  assign o_active_ch = r_active;
  assign o_switching = r_switching;
  assign o_sel_err = r_sel_err;
endmodule
